// File: rtl/exe_delay_seq.sv
// -----------------------------------------------------------------------------
// exe_delay_seq
//
// Execution-side sequencer. It takes one decoded instruction at a time from
// the operand decoder, launches the ALU when the instruction needs it, and
// holds fetch/decode until one of two things happens: the decoded delay runs
// out, or the ALU reports completion (unbounded delay). When the instruction
// finishes it emits a one-cycle write-back strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   issue_valid  decoded instruction present this cycle
//   opr_typ_sel  decoded operation type
//   alu_req      instruction uses the ALU
//   dly_sel      decoded src_dst_delay_sel
//   dly          decoded src_dst_delay (all-ones = wait for alu_done)
//   alu_done     ALU completion pulse
//   flush        synchronous cancel (taken jump / abort)
//   issue_ready  sequencer can accept an instruction (IDLE)
//   stall        hold fetch/decode (not IDLE)
//   alu_start    one-cycle ALU launch pulse
//   wb_en        one-cycle write-back strobe
//   cur_opr      operation type of the instruction in flight
//   dly_cnt      remaining delay cycles
//   issue_err    sticky flag: issue attempted while busy
// -----------------------------------------------------------------------------
module exe_delay_seq #(
  parameter int OPR_W = 5,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [OPR_W-1:0] opr_typ_sel,
  input  logic             alu_req,
  input  logic             dly_sel,
  input  logic [DLY_W-1:0] dly,
  input  logic             alu_done,
  input  logic             flush,
  output logic             issue_ready,
  output logic             stall,
  output logic             alu_start,
  output logic             wb_en,
  output logic [OPR_W-1:0] cur_opr,
  output logic [DLY_W-1:0] dly_cnt,
  output logic             issue_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // All-ones delay means "no count, wait for alu_done".
  localparam logic [DLY_W-1:0] DLY_INF  = '1;
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_ZERO = '0;

  state_e             state_q, state_d;
  logic               alu_start_q, alu_start_d;
  logic               wb_en_q, wb_en_d;
  logic [OPR_W-1:0]   cur_opr_q, cur_opr_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic               issue_err_q, issue_err_d;

  logic               idle;
  logic               accept;
  logic               needs_wait;

  assign idle       = (state_q == S_IDLE);
  // A flush in the same cycle drops the instruction entirely.
  assign accept     = idle && issue_valid && !flush;
  assign needs_wait = dly_sel && (dly != DLY_ZERO);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            state_d = needs_wait ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          if (dly_cnt_q == DLY_INF) begin
            // Unbounded: alu_done may coincide with the alu_start cycle.
            if (alu_done) begin
              state_d = S_DONE;
            end
          end else if (dly_cnt_q == DLY_ONE) begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_opr_d   = cur_opr_q;
    dly_cnt_d   = dly_cnt_q;
    alu_start_d = accept && alu_req && dly_sel;
    // DONE lasts exactly one cycle, so this yields a single-cycle strobe.
    wb_en_d     = (state_d == S_DONE);
    // Issuing while busy is a protocol violation; the instruction is ignored.
    issue_err_d = issue_err_q || (issue_valid && !idle);

    if (accept) begin
      cur_opr_d = opr_typ_sel;
    end

    if (flush) begin
      dly_cnt_d = DLY_ZERO;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue_valid && needs_wait) begin
            dly_cnt_d = dly;
          end
        end
        S_WAIT: begin
          if (state_d == S_DONE) begin
            dly_cnt_d = DLY_ZERO;
          end else if (dly_cnt_q != DLY_INF) begin
            dly_cnt_d = dly_cnt_q - DLY_ONE;
          end
        end
        S_DONE:  dly_cnt_d = DLY_ZERO;
        default: dly_cnt_d = DLY_ZERO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_start_q <= 1'b0;
      wb_en_q     <= 1'b0;
      cur_opr_q   <= '0;
      dly_cnt_q   <= '0;
      issue_err_q <= 1'b0;
    end else begin
      alu_start_q <= alu_start_d;
      wb_en_q     <= wb_en_d;
      cur_opr_q   <= cur_opr_d;
      dly_cnt_q   <= dly_cnt_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign issue_ready = idle;
  assign stall       = !idle;
  assign alu_start   = alu_start_q;
  assign wb_en       = wb_en_q;
  assign cur_opr     = cur_opr_q;
  assign dly_cnt     = dly_cnt_q;
  assign issue_err   = issue_err_q;

endmodule

// File: doc/exe_delay_seq.md
Name: exe_delay_seq

Overview:
- Execution-side sequencer that consumes the operand decoder's per-instruction outputs: operation type, ALU request, and the delay pair `src_dst_delay_sel`/`src_dst_delay`.
- Accepts one decoded instruction, fires the ALU start pulse, and stalls fetch/decode for the decoded number of cycles or until the ALU reports completion.
- Emits a one-cycle write-back strobe when the instruction completes.
- Sits between the decoder and the datapath write-back/PC-advance logic.

Parameters:
- OPR_W, 5, width of the operation-type code.
- DLY_W, 8, width of the delay field; the all-ones value means "unbounded, wait for alu_done".

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- issue_valid  in  1  decoded instruction present this cycle.
- opr_typ_sel  in  OPR_W  decoded operation type.
- alu_req  in  1  instruction uses the ALU (alu_o_sel & alu_t_sel).
- dly_sel  in  1  decoded src_dst_delay_sel.
- dly  in  DLY_W  decoded src_dst_delay.
- alu_done  in  1  ALU completion pulse.
- flush  in  1  synchronous cancel (taken jump / abort).
- issue_ready  out  1  sequencer can accept an instruction.
- stall  out  1  hold fetch/decode.
- alu_start  out  1  one-cycle ALU launch pulse.
- wb_en  out  1  one-cycle completion/write-back strobe.
- cur_opr  out  OPR_W  operation type of the instruction in flight.
- dly_cnt  out  DLY_W  remaining delay cycles.
- issue_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - issue_ready=1.
  - stall=0, alu_start=0, wb_en=0, issue_err=0.
  - cur_opr=0, dly_cnt=0.
- FSM states: IDLE, WAIT, DONE. All outputs are registered except:
  - issue_ready = (state==IDLE);
  - stall = (state!=IDLE).
- IDLE, issue_valid=1 (accept at cycle T):
  - Latch cur_opr<=opr_typ_sel.
  - If dly_sel=0 or dly=0: go to DONE at T+1.
  - Otherwise: dly_cnt<=dly, go to WAIT at T+1.
- alu_start: high exactly in cycle T+1 iff alu_req=1 and dly_sel=1 at acceptance; never at any other time.
- WAIT, bounded (latched dly != all-ones):
  - dly_cnt decrements by 1 per cycle.
  - When dly_cnt==1, next state is DONE.
  - Accept at T with dly=N gives wb_en at cycle T+N+1 and IDLE/issue_ready at T+N+2.
  - alu_done is ignored in bounded mode.
- WAIT, unbounded (dly == all-ones):
  - dly_cnt holds at all-ones.
  - The cycle after alu_done=1, the FSM is in DONE.
  - alu_done in the same cycle as alu_start is valid and counts.
- DONE: wb_en=1 for exactly this cycle, then IDLE; dly_cnt<=0. cur_opr holds until the next acceptance.
- flush (highest priority, any state):
  - Next state IDLE; dly_cnt<=0; wb_en and alu_start forced 0 next cycle.
  - flush together with issue_valid in IDLE: the instruction is dropped, nothing is latched.
  - flush in DONE suppresses nothing already asserted that cycle; IDLE follows regardless.
- issue_valid=1 while state!=IDLE:
  - The instruction is ignored.
  - issue_err<=1, sticky until reset.
  - The in-flight operation is unaffected.
- alu_done in IDLE or DONE: ignored, no error.
- Reset asserted mid-operation: immediate return to reset values; no wb_en is produced.
- Back-to-back: a new issue is accepted in the first IDLE cycle after DONE, so the minimum issue spacing is 2 cycles (zero delay) and N+2 cycles otherwise.

Test Plan:
- Reset mid-WAIT (dly=20, rst_n low at T+5) -> all outputs zero asynchronously, issue_ready=1 after release, no wb_en.
- Issue MOV-type (opr=1, dly_sel=1, dly=4, alu_req=0) at T -> no alu_start, stall T+1..T+5, wb_en only at T+5, issue_ready at T+6, dly_cnt 4,3,2,1.
- Issue ADD-type (opr=2, alu_req=1, dly=4) -> alu_start at T+1 only, wb_en at T+5, cur_opr=2.
- Issue MUL-type (dly=255, alu_req=1), alu_done at T+40 -> dly_cnt stays 255, wb_en at T+41, IDLE at T+42.
- Issue dly_sel=0 at T, second issue at T+2 -> wb_en at T+1, second accepted at T+2, issue_err=0.
- dly=7 accepted, flush at T+3, plus extra issue_valid at T+2 -> issue_err=1, IDLE at T+4, no wb_en ever, alu_done at T+6 ignored.
